mrd_stage_seq: RTL and testbench

- Top-level sequencer for the single-RAM mixed-radix DFT memory (mrd_mem_top).
- Per packet it orders the phases: sink one frame, then one rd/wr pass per factor stage, then source.
- Issues one-cycle commands carrying state code and current_stage. Tracks completion through the memory's *_ongoing status flags.
- Sits beside the parameter block that supplies NumOfFactors; drives the state/current_stage fields of mrd_ctrl_if.

---
 rtl/mrd_stage_seq.sv | 197 +++++++++++++++++++
 tb/tb_mrd_stage_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mrd_stage_seq.sv
// rtl/mrd_stage_seq.sv - packet phase sequencer (sink, rd/wr per stage, source) for mrd_mem_top
// Optional watchdog on missing *_ongoing flags: define MRD_SEQ_WDOG_EN.
module mrd_stage_seq #(
  parameter int WDOG_CYC = 64,
  parameter int STG_W    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sink_sop,
  input  logic [STG_W-1:0] num_factors,
  input  logic             sink_ongoing,
  input  logic             rd_ongoing,
  input  logic             wr_ongoing,
  input  logic             source_ongoing,
  output logic             cmd_vld,
  output logic [1:0]       cmd_state,
  output logic [STG_W-1:0] current_stage,
  output logic             busy,
  output logic             pkt_done,
  output logic             overrun,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE, S_SINK, S_WAITSRC, S_RD, S_WR, S_SRC
  } state_t;

  localparam logic [1:0]       CMD_SINK = 2'b00;
  localparam logic [1:0]       CMD_RD   = 2'b01;
  localparam logic [1:0]       CMD_WR   = 2'b10;
  localparam logic [1:0]       CMD_SRC  = 2'b11;
  localparam logic [STG_W-1:0] NF_MAX   = STG_W'(6);

  state_t           state_q, state_d;
  logic [STG_W-1:0] stage_q, stage_d;
  logic [STG_W-1:0] nf_q, nf_d;
  logic [1:0]       cmd_state_q, cmd_state_d;
  logic             cmd_vld_q, cmd_vld_d;
  logic             pkt_done_q, pkt_done_d;
  logic             seen_hi_q, seen_hi_d;
  logic             overrun_q, overrun_d;
  logic             err_q, err_d;

  logic phase_ongoing;
  logic seen;
  logic phase_done;
  logic wdog_expire;

  // Only the flag belonging to the current phase is watched.
  always_comb begin
    phase_ongoing = 1'b0;
    case (state_q)
      S_SINK:  phase_ongoing = sink_ongoing;
      S_RD:    phase_ongoing = rd_ongoing;
      S_WR:    phase_ongoing = wr_ongoing;
      default: phase_ongoing = 1'b0;
    endcase
    seen       = seen_hi_q | phase_ongoing;
    phase_done = seen_hi_q & ~phase_ongoing;
  end

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    nf_d        = nf_q;
    cmd_state_d = cmd_state_q;
    cmd_vld_d   = 1'b0;
    pkt_done_d  = 1'b0;
    seen_hi_d   = seen;
    overrun_d   = overrun_q;
    err_d       = err_q;

    if (sink_sop && (state_q != S_IDLE)) overrun_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (sink_sop) begin
          state_d     = S_SINK;
          cmd_vld_d   = 1'b1;
          cmd_state_d = CMD_SINK;
          stage_d     = '0;
        end
      end
      S_SINK: begin
        if (phase_done) begin
          nf_d    = (num_factors > NF_MAX) ? NF_MAX : num_factors;
          state_d = S_WAITSRC;
        end
      end
      S_WAITSRC: begin
        if (!source_ongoing) begin
          cmd_vld_d = 1'b1;
          stage_d   = '0;
          if (nf_q == '0) begin
            state_d     = S_SRC;
            cmd_state_d = CMD_SRC;
            pkt_done_d  = 1'b1;
          end else begin
            state_d     = S_RD;
            cmd_state_d = CMD_RD;
          end
        end
      end
      S_RD: begin
        if (phase_done) begin
          state_d     = S_WR;
          cmd_vld_d   = 1'b1;
          cmd_state_d = CMD_WR;
        end
      end
      S_WR: begin
        if (phase_done) begin
          cmd_vld_d = 1'b1;
          if (stage_q == (nf_q - STG_W'(1))) begin
            state_d     = S_SRC;
            cmd_state_d = CMD_SRC;
            stage_d     = '0;
            pkt_done_d  = 1'b1;
          end else begin
            state_d     = S_RD;
            cmd_state_d = CMD_RD;
            stage_d     = stage_q + STG_W'(1);
          end
        end
      end
      S_SRC:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Watchdog abandons the packet silently: no command, no pkt_done.
    if (wdog_expire) begin
      state_d    = S_IDLE;
      cmd_vld_d  = 1'b0;
      pkt_done_d = 1'b0;
      err_d      = 1'b1;
    end

    if (cmd_vld_d) seen_hi_d = 1'b0;
  end

`ifdef MRD_SEQ_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYC + 1);

  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            wdog_run;

  always_comb begin
    wdog_run    = ((state_q == S_SINK) || (state_q == S_RD) || (state_q == S_WR)) && !seen;
    wdog_expire = wdog_run && (wdog_q == WD_W'(WDOG_CYC - 1));
    wdog_d      = wdog_q;
    if (cmd_vld_d)     wdog_d = '0;
    else if (wdog_run) wdog_d = wdog_q + WD_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wdog_q <= '0;
    else        wdog_q <= wdog_d;
  end
`else
  logic unused_wdog_cyc;
  assign unused_wdog_cyc = (WDOG_CYC != 0);
  assign wdog_expire     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      stage_q     <= '0;
      nf_q        <= '0;
      cmd_state_q <= CMD_SINK;
      cmd_vld_q   <= 1'b0;
      pkt_done_q  <= 1'b0;
      seen_hi_q   <= 1'b0;
      overrun_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      nf_q        <= nf_d;
      cmd_state_q <= cmd_state_d;
      cmd_vld_q   <= cmd_vld_d;
      pkt_done_q  <= pkt_done_d;
      seen_hi_q   <= seen_hi_d;
      overrun_q   <= overrun_d;
      err_q       <= err_d;
    end
  end

  assign cmd_vld       = cmd_vld_q;
  assign cmd_state     = cmd_state_q;
  assign current_stage = stage_q;
  assign busy          = (state_q != S_IDLE);
  assign pkt_done      = pkt_done_q;
  assign overrun       = overrun_q;
  assign err           = err_q;

endmodule

// File: tb/tb_mrd_stage_seq.sv
// tb/tb_mrd_stage_seq.sv - directed bench for mrd_stage_seq with a small memory-status model
`timescale 1ns/1ps
module tb_mrd_stage_seq;
  localparam int STG_W    = 3;
  localparam int WDOG_CYC = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             sink_sop;
  logic [STG_W-1:0] num_factors;
  logic             sink_ongoing, rd_ongoing, wr_ongoing, source_ongoing;
  logic             cmd_vld;
  logic [1:0]       cmd_state;
  logic [STG_W-1:0] current_stage;
  logic             busy, pkt_done, overrun, err;

  mrd_stage_seq #(.WDOG_CYC(WDOG_CYC), .STG_W(STG_W)) dut (
    .clk(clk), .rst_n(rst_n), .sink_sop(sink_sop), .num_factors(num_factors),
    .sink_ongoing(sink_ongoing), .rd_ongoing(rd_ongoing), .wr_ongoing(wr_ongoing),
    .source_ongoing(source_ongoing), .cmd_vld(cmd_vld), .cmd_state(cmd_state),
    .current_stage(current_stage), .busy(busy), .pkt_done(pkt_done),
    .overrun(overrun), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_done = 0;
  int q_state[$];
  int q_stage[$];
  int q_cyc[$];
  int dly[4];
  int cnt[4];
  logic rd_block;
  logic src_force;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: each ongoing flag rises 2 cycles after its command, stays high 10 cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin dly[i] = 0; cnt[i] = 0; end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (dly[i] != 0) begin
          dly[i] = dly[i] - 1;
          if (dly[i] == 0) cnt[i] = 10;
        end else if (cnt[i] != 0) begin
          cnt[i] = cnt[i] - 1;
        end
      end
      if (cmd_vld) begin
        dly[cmd_state] = 2;
        q_state.push_back(int'(cmd_state));
        q_stage.push_back(int'(current_stage));
        q_cyc.push_back(cyc);
      end
      if (pkt_done) n_done = n_done + 1;
    end
  end

  assign sink_ongoing   = (cnt[0] != 0);
  assign rd_ongoing     = (cnt[1] != 0) && !rd_block;
  assign wr_ongoing     = (cnt[2] != 0);
  assign source_ongoing = (cnt[3] != 0) || src_force;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic clear_log();
    q_state.delete(); q_stage.delete(); q_cyc.delete();
  endtask

  task automatic check_reset(input string tag);
    chk($sformatf("%s_cmd_vld", tag), int'(cmd_vld), 0);
    chk($sformatf("%s_cmd_state", tag), int'(cmd_state), 0);
    chk($sformatf("%s_stage", tag), int'(current_stage), 0);
    chk($sformatf("%s_busy", tag), int'(busy), 0);
    chk($sformatf("%s_pkt_done", tag), int'(pkt_done), 0);
    chk($sformatf("%s_overrun", tag), int'(overrun), 0);
    chk($sformatf("%s_err", tag), int'(err), 0);
  endtask

  task automatic pulse_sop();
    sink_sop = 1'b1;
    step(1);
    sink_sop = 1'b0;
  endtask

  task automatic wait_log(input string tag, input int n);
    int k = 0;
    while (q_state.size() < n && k < 1000) begin step(1); k++; end
    chk($sformatf("%s_log_reached", tag), int'(q_state.size() >= n), 1);
  endtask

  task automatic wait_done(input string tag, input int d0);
    int k = 0;
    while (n_done == d0 && k < 1000) begin step(1); k++; end
    chk($sformatf("%s_done_seen", tag), int'(n_done > d0), 1);
    step(2);
    chk($sformatf("%s_done_once", tag), n_done - d0, 1);
    chk($sformatf("%s_busy_after", tag), int'(busy), 0);
  endtask

  // Expected: sink(0), then rd/wr at stages 0..nf-1 (nf clamped to 6), then source(0).
  task automatic check_seq(input string tag, input int nf);
    int nfc = (nf > 6) ? 6 : nf;
    chk($sformatf("%s_len", tag), q_state.size(), 2 * nfc + 2);
    if (q_state.size() == 2 * nfc + 2) begin
      chk($sformatf("%s_first", tag), q_state[0], 0);
      for (int s = 0; s < nfc; s++) begin
        chk($sformatf("%s_rd%0d", tag, s), q_state[1 + 2 * s], 1);
        chk($sformatf("%s_rd%0d_stg", tag, s), q_stage[1 + 2 * s], s);
        chk($sformatf("%s_wr%0d", tag, s), q_state[2 + 2 * s], 2);
        chk($sformatf("%s_wr%0d_stg", tag, s), q_stage[2 + 2 * s], s);
      end
      chk($sformatf("%s_last", tag), q_state[2 * nfc + 1], 3);
      chk($sformatf("%s_last_stg", tag), q_stage[2 * nfc + 1], 0);
    end
  endtask

  task automatic run_packet(input string tag, input int nf);
    int d0;
    clear_log();
    d0 = n_done;
    num_factors = STG_W'(nf);
    pulse_sop();
    wait_done(tag, d0);
    check_seq(tag, nf);
  endtask

  initial begin
    int d0;
    int c_drop;
    int n_before;
    int r_cyc;
    int k;
    rst_n = 1'b0;
    sink_sop = 1'b0;
    num_factors = '0;
    rd_block = 1'b0;
    src_force = 1'b0;
    step(3);
    check_reset("rst");
    rst_n = 1'b1;
    step(2);
    check_reset("idle");

    run_packet("nf5", 5);
    run_packet("nf0", 0);
    run_packet("nf7clamp", 7);

    clear_log();
    d0 = n_done;
    num_factors = STG_W'(2);
    src_force = 1'b1;
    pulse_sop();
    step(60);
    chk("srchold_only_sink", q_state.size(), 1);
    chk("srchold_busy", int'(busy), 1);
    c_drop = cyc;
    src_force = 1'b0;
    wait_done("srchold", d0);
    check_seq("srchold", 2);
    if (q_cyc.size() >= 2) chk("srchold_rd_cycle", q_cyc[1], c_drop + 1);

    clear_log();
    d0 = n_done;
    num_factors = STG_W'(3);
    chk("ovr_pre", int'(overrun), 0);
    pulse_sop();
    wait_log("ovr", 7);
    chk("ovr_in_wr2", int'(busy), 1);
    pulse_sop();
    step(1);
    chk("ovr_set", int'(overrun), 1);
    wait_done("ovr", d0);
    check_seq("ovr", 3);
    chk("ovr_sticky", int'(overrun), 1);

    clear_log();
    num_factors = STG_W'(4);
    pulse_sop();
    wait_log("midrst", 4);
    step(2);
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    step(5);
    rst_n = 1'b1;
    n_before = q_state.size();
    step(30);
    chk("midrst_no_cmd", q_state.size(), n_before);
    chk("midrst_idle", int'(busy), 0);
    run_packet("postrst", 2);

`ifdef MRD_SEQ_WDOG_EN
    clear_log();
    d0 = n_done;
    rd_block = 1'b1;
    num_factors = STG_W'(1);
    pulse_sop();
    wait_log("wdog", 2);
    r_cyc = (q_cyc.size() >= 2) ? q_cyc[1] : 0;
    k = 0;
    while (!err && k < 300) begin step(1); k++; end
    chk("wdog_err", int'(err), 1);
    chk("wdog_err_cycle", cyc, r_cyc + WDOG_CYC);
    chk("wdog_idle", int'(busy), 0);
    chk("wdog_no_done", n_done - d0, 0);
    chk("wdog_cmds", q_state.size(), 2);
    rd_block = 1'b0;
    step(20);
    run_packet("wdog_next", 1);
    chk("wdog_err_sticky", int'(err), 1);
`else
    r_cyc = 0;
    k = 0;
    chk("no_wdog_err", int'(err), r_cyc + k);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
